axi_lite_uart_regs: RTL and testbench
=====================================

# axi_lite_uart_regs

AXI4-Lite slave register file that terminates the lite-side port of the AXI-to-AXI-Lite ID-reflect stage and drives the UART core. It decodes five word registers: control, status, baud divisor, TX data and RX data. It converts TX_DATA writes and RX_DATA reads into valid/ready handshakes toward the UART TX/RX FIFOs. It always returns exactly one B per AW/W pair and one R per AR, in order.

## Interface
- AddrWidth, 32, lite address width; decode uses addr[4:2], addr[1:0] must be 0
- DataWidth, 32, lite data width (fixed 32; other values are an elaboration error)
- DefaultBaudDiv, 16'd434, reset value of BAUD_DIV
- lite_req_t, logic, AXI-Lite request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready)
- lite_resp_t, logic, AXI-Lite response struct (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid)

Ports:
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- slv_req_i  in  lite_req_t  lite request from upstream
- slv_resp_o  out  lite_resp_t  lite response to upstream
- tx_data_o  out  8  byte to the UART TX FIFO
- tx_valid_o  out  1  TX push request
- tx_ready_i  in  1  TX FIFO not full
- rx_data_i  in  8  head byte of the UART RX FIFO
- rx_valid_i  in  1  RX FIFO not empty
- rx_ready_o  out  1  RX pop; single-cycle pulse
- rx_overrun_i  in  1  one-cycle pulse on RX FIFO overflow
- baud_div_o  out  16  baud divisor
- tx_en_o, rx_en_o, stop2_o  out  1 each  CTRL bits
- irq_o  out  1  interrupt; present only with AXI_LITE_UART_IRQ_EN

## Operation
- Register map:
  - 0x00 CTRL, RW. Bit 0 tx_en, bit 1 rx_en, bit 2 stop2, bit 4 irq_en (macro only).
  - 0x04 STATUS, RO except bit 2. Bit 0 tx_ready_i, bit 1 rx_valid_i, bit 2 overrun (sticky, W1C), bit 3 irq_pending.
  - 0x08 BAUD_DIV, RW, bits [15:0].
  - 0x0C TX_DATA, WO, bits [7:0].
  - 0x10 RX_DATA, RO. Bit 8 = byte valid, bits [7:0] = data.
- Byte strobes apply to CTRL and BAUD_DIV. A TX_DATA write pushes only if strb[0]=1; otherwise it returns OKAY with no push.
- Unmapped address, misaligned address, write to RX_DATA, or read of TX_DATA returns SLVERR (2'b10) with no side effect; read data is 0.
- Write FSM W_IDLE → W_TX → W_RESP:
  - W_IDLE: aw_ready = w_ready = aw_valid & w_valid. AW and W are accepted in the same cycle only.
  - If the accepted write targets TX_DATA with strb[0]=1, go to W_TX. Otherwise apply the write and go to W_RESP.
  - W_TX: tx_valid_o=1 holding the byte. On tx_ready_i, go to W_RESP.
  - W_RESP: b_valid=1 until b_ready, then return to W_IDLE.
- Read FSM R_IDLE → R_RESP:
  - R_IDLE: ar_ready=1. On handshake, register rdata/resp and go to R_RESP.
  - R_RESP: r_valid=1, r data stable until r_ready, then return to R_IDLE.
- RX_DATA read:
  - If rx_valid_i is high on the AR handshake cycle, rx_ready_o pulses that cycle and rdata = {23'b0, 1'b1, rx_data_i}.
  - Otherwise rdata = 0 and resp = OKAY.
- Overrun: rx_overrun_i sets STATUS[2]. If a W1C and rx_overrun_i occur in the same cycle, set wins.
- The read and write FSMs are independent. A read of STATUS returns the value before any write applied in the same cycle.

## Timing
- Reset values: all ready/valid outputs 0, rx_ready_o 0, tx_valid_o 0, tx_data_o 0, CTRL 0 (tx_en_o/rx_en_o/stop2_o 0), baud_div_o = DefaultBaudDiv, overrun 0, irq_o 0, both FSMs in IDLE.
- Register write to B: the write takes effect on the handshake edge and b_valid rises the next cycle, so minimum latency is 1 cycle.
- TX_DATA: tx_valid_o rises the cycle after the handshake. b_valid rises the cycle after tx_ready_i is seen.
- AR to R: r_valid rises the next cycle, so latency is 1. Throughput is one read per 2 cycles.
- Once asserted, tx_valid_o and tx_data_o hold until the handshake completes.
- rst_i asserted at any point, including mid-W_TX or mid-R_RESP, returns to reset values on the next edge. Pending responses are dropped.

## Configuration
- AXI_LITE_UART_IRQ_EN defined:
  - CTRL[4] irq_en is implemented and irq_o exists.
  - irq_pending = rx_valid_i | overrun.
  - irq_o = irq_en & irq_pending, registered (one cycle of latency).
- Undefined: CTRL[4] reads 0 and ignores writes, STATUS[3] reads 0, irq_o port is absent.

## Structure
- Package axi_lite_uart_pkg holds the register offset localparams, CTRL/STATUS bit-index constants, resp codes (OKAY=2'b00, SLVERR=2'b10), and the write/read FSM state enums.
- Sub-module axi_lite_uart_decode: combinational address-to-register-select with a legality flag, shared by the read and write paths.

## Test plan
- Write 0x0000_01B2 to 0x08 with strb=4'b0011, then read 0x08 → baud_div_o=16'h01B2; read returns 0x0000_01B2, OKAY.
- Write 0x41 to 0x0C with tx_ready_i held low for 5 cycles → tx_valid_o high for 6 cycles with tx_data_o=8'h41; b_valid rises 1 cycle after tx_ready_i; resp OKAY.
- rx_valid_i=1, rx_data_i=8'h5A, read 0x10 → one rx_ready_o pulse; rdata 0x0000_015A. Repeat with rx_valid_i=0 → rdata 0, no pulse.
- Read 0x14, read 0x06, write 0x10 → SLVERR each; no register change; no FIFO handshake.
- Pulse rx_overrun_i, read 0x04 → bit 2 set. Write 0x4 to 0x04 → bit 2 cleared. Repeat with the clear and a new pulse in the same cycle → bit 2 stays 1.
- Assert rst_i during W_TX → next cycle tx_valid_o=0, b_valid=0, CTRL=0, baud_div_o=434.

Source files
------------

// File: rtl/axi_lite_uart_pkg.sv
// Shared definitions for the AXI4-Lite UART register block.
// Contents: AXI-Lite channel and request/response structs, register offsets,
// CTRL/STATUS bit indices, response codes, FSM state enums and the
// register-select enum produced by axi_lite_uart_decode.
package axi_lite_uart_pkg;

  localparam int unsigned LiteAddrW = 32;
  localparam int unsigned LiteDataW = 32;

  typedef struct packed {
    logic [LiteAddrW-1:0] addr;
    logic [2:0]           prot;
  } axi_lite_ax_t;

  typedef struct packed {
    logic [LiteDataW-1:0] data;
    logic [3:0]           strb;
  } axi_lite_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_lite_b_t;

  typedef struct packed {
    logic [LiteDataW-1:0] data;
    logic [1:0]           resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_ax_t aw;
    logic         aw_valid;
    axi_lite_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_lite_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_lite_b_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_lite_r_t r;
    logic        r_valid;
  } axi_lite_resp_t;

  // Register byte offsets
  localparam logic [4:0] REG_CTRL    = 5'h00;
  localparam logic [4:0] REG_STATUS  = 5'h04;
  localparam logic [4:0] REG_BAUD    = 5'h08;
  localparam logic [4:0] REG_TX_DATA = 5'h0C;
  localparam logic [4:0] REG_RX_DATA = 5'h10;

  // CTRL bits
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_RX_EN  = 1;
  localparam int CTRL_STOP2  = 2;
  localparam int CTRL_IRQ_EN = 4;

  // STATUS bits
  localparam int STS_TX_READY = 0;
  localparam int STS_RX_VALID = 1;
  localparam int STS_OVERRUN  = 2;
  localparam int STS_IRQ_PEND = 3;

  // RX_DATA byte-valid flag
  localparam int RX_VALID_BIT = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_TX   = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  typedef enum logic [2:0] {
    SEL_CTRL   = 3'd0,
    SEL_STATUS = 3'd1,
    SEL_BAUD   = 3'd2,
    SEL_TX     = 3'd3,
    SEL_RX     = 3'd4,
    SEL_NONE   = 3'd7
  } reg_sel_e;

endpackage

// File: rtl/axi_lite_uart_decode.sv
// Address decoder shared by the read and write paths.
// Ports:
//   i_addr : lite address (only [4:2] select a register, [1:0] must be 0)
//   o_sel  : selected register, SEL_NONE when unmapped
//   o_hit  : address is mapped and word aligned
// Direction legality (RO/WO registers) is checked by the caller.
module axi_lite_uart_decode
  import axi_lite_uart_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic [AddrWidth-1:0] i_addr,
  output reg_sel_e             o_sel,
  output logic                 o_hit
);

  always_comb begin
    o_sel = SEL_NONE;
    case (i_addr[4:2])
      REG_CTRL[4:2]:    o_sel = SEL_CTRL;
      REG_STATUS[4:2]:  o_sel = SEL_STATUS;
      REG_BAUD[4:2]:    o_sel = SEL_BAUD;
      REG_TX_DATA[4:2]: o_sel = SEL_TX;
      REG_RX_DATA[4:2]: o_sel = SEL_RX;
      default:          o_sel = SEL_NONE;
    endcase
    o_hit = (o_sel != SEL_NONE) && (i_addr[1:0] == 2'b00);
  end

  // Upper address bits do not take part in the decode.
  if (AddrWidth > 5) begin : g_upper
    logic w_unused_upper;
    assign w_unused_upper = ^i_addr[AddrWidth-1:5];
  end

endmodule

// File: rtl/axi_lite_uart_regs.sv
// AXI4-Lite slave register file in front of a UART core.
// Registers: CTRL 0x00, STATUS 0x04, BAUD_DIV 0x08, TX_DATA 0x0C, RX_DATA 0x10.
// TX_DATA writes become a valid/ready push toward the TX FIFO; RX_DATA reads
// pop the RX FIFO when it holds a byte. One B per AW/W pair, one R per AR.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   slv_req_i/slv_resp_o  : AXI-Lite slave port
//   tx_data_o/tx_valid_o/tx_ready_i : TX FIFO push
//   rx_data_i/rx_valid_i/rx_ready_o : RX FIFO pop (rx_ready_o is one cycle)
//   rx_overrun_i          : RX overflow pulse, latched into STATUS[2]
//   baud_div_o, tx_en_o, rx_en_o, stop2_o : configuration outputs
//   irq_o                 : interrupt, only when AXI_LITE_UART_IRQ_EN is defined
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; the source holds its payload stable until that edge.
// Optional feature macro: AXI_LITE_UART_IRQ_EN (CTRL[4] irq_en, STATUS[3], irq_o).
module axi_lite_uart_regs
  import axi_lite_uart_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter logic [15:0] DefaultBaudDiv = 16'd434,
  parameter type         lite_req_t     = axi_lite_req_t,
  parameter type         lite_resp_t    = axi_lite_resp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  lite_req_t   slv_req_i,
  output lite_resp_t  slv_resp_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic        rx_overrun_i,
  output logic [15:0] baud_div_o,
  output logic        tx_en_o,
  output logic        rx_en_o,
  output logic        stop2_o
`ifdef AXI_LITE_UART_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  if (DataWidth != 32) begin : g_dw_check
    $error("axi_lite_uart_regs: DataWidth must be 32");
  end

  wr_state_e   r_wstate;
  rd_state_e   r_rstate;
  logic [1:0]  r_bresp;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;
  logic [7:0]  r_tx_data;
  logic        r_tx_en;
  logic        r_rx_en;
  logic        r_stop2;
  logic [15:0] r_baud;
  logic        r_overrun;

  reg_sel_e    w_wsel;
  reg_sel_e    w_rsel;
  logic        w_whit;
  logic        w_rhit;
  logic        w_aw_hs;
  logic        w_ar_hs;
  logic        w_wlegal;
  logic        w_rlegal;
  logic        w_tx_push;
  logic        w_ovr_clr;
  logic        w_irq_pend;
  logic        w_irq_en_rd;
  logic [31:0] w_wdata;
  logic [3:0]  w_strb;
  logic [31:0] w_rd_data;

  axi_lite_uart_decode #(.AddrWidth(AddrWidth)) u_wdec (
    .i_addr (slv_req_i.aw.addr[AddrWidth-1:0]),
    .o_sel  (w_wsel),
    .o_hit  (w_whit)
  );

  axi_lite_uart_decode #(.AddrWidth(AddrWidth)) u_rdec (
    .i_addr (slv_req_i.ar.addr[AddrWidth-1:0]),
    .o_sel  (w_rsel),
    .o_hit  (w_rhit)
  );

  assign w_wdata = slv_req_i.w.data;
  assign w_strb  = slv_req_i.w.strb;

  // AW and W are only taken together, and never while reset is held.
  assign w_aw_hs  = (r_wstate == W_IDLE) && !rst_i && slv_req_i.aw_valid && slv_req_i.w_valid;
  assign w_ar_hs  = (r_rstate == R_IDLE) && !rst_i && slv_req_i.ar_valid;
  assign w_wlegal = w_whit && (w_wsel != SEL_RX);
  assign w_rlegal = w_rhit && (w_rsel != SEL_TX);
  assign w_tx_push = w_aw_hs && w_wlegal && (w_wsel == SEL_TX) && w_strb[0];
  assign w_ovr_clr = w_aw_hs && w_wlegal && (w_wsel == SEL_STATUS) && w_strb[0] && w_wdata[STS_OVERRUN];

  // The pop happens on the AR handshake itself, so the byte is sampled there.
  assign rx_ready_o = w_ar_hs && w_rlegal && (w_rsel == SEL_RX) && rx_valid_i;

`ifdef AXI_LITE_UART_IRQ_EN
  logic r_irq_en;
  logic r_irq;
  assign w_irq_pend  = rx_valid_i | r_overrun;
  assign w_irq_en_rd = r_irq_en;
  assign irq_o       = r_irq;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_irq <= 1'b0;
    else       r_irq <= r_irq_en & w_irq_pend;
  end
`else
  assign w_irq_pend  = 1'b0;
  assign w_irq_en_rd = 1'b0;
`endif

  // Read data uses pre-edge register values, so a same-cycle write is not seen.
  always_comb begin
    w_rd_data = '0;
    case (w_rsel)
      SEL_CTRL: begin
        w_rd_data[CTRL_TX_EN]  = r_tx_en;
        w_rd_data[CTRL_RX_EN]  = r_rx_en;
        w_rd_data[CTRL_STOP2]  = r_stop2;
        w_rd_data[CTRL_IRQ_EN] = w_irq_en_rd;
      end
      SEL_STATUS: begin
        w_rd_data[STS_TX_READY] = tx_ready_i;
        w_rd_data[STS_RX_VALID] = rx_valid_i;
        w_rd_data[STS_OVERRUN]  = r_overrun;
        w_rd_data[STS_IRQ_PEND] = w_irq_pend;
      end
      SEL_BAUD: w_rd_data[15:0] = r_baud;
      SEL_RX: begin
        if (rx_valid_i) begin
          w_rd_data[RX_VALID_BIT] = 1'b1;
          w_rd_data[7:0]          = rx_data_i;
        end
      end
      default: w_rd_data = '0;
    endcase
  end

  // Write FSM and writable registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wstate  <= W_IDLE;
      r_bresp   <= RESP_OKAY;
      r_tx_data <= 8'h00;
      r_tx_en   <= 1'b0;
      r_rx_en   <= 1'b0;
      r_stop2   <= 1'b0;
      r_baud    <= DefaultBaudDiv;
      r_overrun <= 1'b0;
`ifdef AXI_LITE_UART_IRQ_EN
      r_irq_en  <= 1'b0;
`endif
    end else begin
      // A new overrun beats a simultaneous W1C.
      if (rx_overrun_i)   r_overrun <= 1'b1;
      else if (w_ovr_clr) r_overrun <= 1'b0;

      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            if (!w_wlegal) begin
              r_bresp  <= RESP_SLVERR;
              r_wstate <= W_RESP;
            end else if (w_tx_push) begin
              r_tx_data <= w_wdata[7:0];
              r_bresp   <= RESP_OKAY;
              r_wstate  <= W_TX;
            end else begin
              r_bresp  <= RESP_OKAY;
              r_wstate <= W_RESP;
              case (w_wsel)
                SEL_CTRL: begin
                  if (w_strb[0]) begin
                    r_tx_en <= w_wdata[CTRL_TX_EN];
                    r_rx_en <= w_wdata[CTRL_RX_EN];
                    r_stop2 <= w_wdata[CTRL_STOP2];
`ifdef AXI_LITE_UART_IRQ_EN
                    r_irq_en <= w_wdata[CTRL_IRQ_EN];
`endif
                  end
                end
                SEL_BAUD: begin
                  if (w_strb[0]) r_baud[7:0]  <= w_wdata[7:0];
                  if (w_strb[1]) r_baud[15:8] <= w_wdata[15:8];
                end
                default: ;
              endcase
            end
          end
        end
        W_TX:    if (tx_ready_i) r_wstate <= W_RESP;
        W_RESP:  if (slv_req_i.b_ready) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata  <= w_rlegal ? w_rd_data : 32'h0;
            r_rresp  <= w_rlegal ? RESP_OKAY : RESP_SLVERR;
            r_rstate <= R_RESP;
          end
        end
        R_RESP:  if (slv_req_i.r_ready) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = w_aw_hs;
    slv_resp_o.w_ready  = w_aw_hs;
    slv_resp_o.b.resp   = r_bresp;
    slv_resp_o.b_valid  = (r_wstate == W_RESP);
    slv_resp_o.ar_ready = (r_rstate == R_IDLE) && !rst_i;
    slv_resp_o.r.data   = r_rdata;
    slv_resp_o.r.resp   = r_rresp;
    slv_resp_o.r_valid  = (r_rstate == R_RESP);
  end

  assign tx_valid_o = (r_wstate == W_TX);
  assign tx_data_o  = r_tx_data;
  assign baud_div_o = r_baud;
  assign tx_en_o    = r_tx_en;
  assign rx_en_o    = r_rx_en;
  assign stop2_o    = r_stop2;

  logic w_unused;
  assign w_unused = ^{slv_req_i.aw.prot, slv_req_i.ar.prot, w_wdata[31:16], w_strb[3:2]};

endmodule

// File: tb/tb_axi_lite_uart_regs.sv
// Directed, table-driven bench for axi_lite_uart_regs plus hand-written
// sequences for TX back-pressure, overrun W1C, irq (macro build) and reset.
module tb_axi_lite_uart_regs;
  import axi_lite_uart_pkg::*;

`ifdef AXI_LITE_UART_IRQ_EN
  localparam logic [31:0] CTRL17_RB = 32'h17;
  localparam logic [31:0] STS_RXV   = 32'h0A;
  localparam logic [31:0] STS_OVR   = 32'h0C;
`else
  localparam logic [31:0] CTRL17_RB = 32'h07;
  localparam logic [31:0] STS_RXV   = 32'h02;
  localparam logic [31:0] STS_OVR   = 32'h04;
`endif

  logic           clk = 1'b0;
  logic           rst;
  axi_lite_req_t  req;
  axi_lite_resp_t rsp;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           rx_ready;
  logic           rx_overrun;
  logic [15:0]    baud;
  logic           tx_en, rx_en, stop2;
`ifdef AXI_LITE_UART_IRQ_EN
  logic           irq;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;

  axi_lite_uart_regs dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .slv_req_i    (req),
    .slv_resp_o   (rsp),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_ready_o   (rx_ready),
    .rx_overrun_i (rx_overrun),
    .baud_div_o   (baud),
    .tx_en_o      (tx_en),
    .rx_en_o      (rx_en),
    .stop2_o      (stop2)
`ifdef AXI_LITE_UART_IRQ_EN
    ,
    .irq_o        (irq)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // FIFO-side event counters
  always @(posedge clk) begin
    if (tx_valid && tx_ready) push_cnt++;
    if (rx_ready) pop_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Driver tasks
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit ovr, output logic [1:0] bresp, output int lat);
    int n;
    req.aw.addr = a;
    req.w.data  = d;
    req.w.strb  = s;
    req.aw_valid = 1'b1;
    req.w_valid  = 1'b1;
    if (ovr) rx_overrun = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rsp.aw_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    rx_overrun   = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rsp.b_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    bresp = rsp.b.resp;
    req.b_ready = 1'b1;
    @(posedge clk); #1;
    req.b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] rresp, output int lat);
    int n;
    req.ar.addr  = a;
    req.ar_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rsp.ar_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rsp.r_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    d     = rsp.r.data;
    rresp = rsp.r.resp;
    req.r_ready = 1'b1;
    @(posedge clk); #1;
    req.r_ready = 1'b0;
  endtask

  task automatic pulse_overrun();
    rx_overrun = 1'b1;
    @(posedge clk); #1;
    rx_overrun = 1'b0;
  endtask

  // Vector table
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          rxv;
    logic [7:0]  rxd;
    bit          txr;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [15:0] baud;
    logic [2:0]  ctrl;
    int          push;
    int          pop;
    int          lat;
  } vec_t;

  function automatic vec_t v(bit wr, logic [31:0] addr, logic [31:0] data, logic [3:0] strb,
                             bit rxv, logic [7:0] rxd, bit txr, logic [1:0] resp,
                             logic [31:0] rdata, logic [15:0] bd, logic [2:0] ctrl,
                             int push, int pop, int lat);
    vec_t t;
    t.wr = wr; t.addr = addr; t.data = data; t.strb = strb;
    t.rxv = rxv; t.rxd = rxd; t.txr = txr; t.resp = resp;
    t.rdata = rdata; t.baud = bd; t.ctrl = ctrl;
    t.push = push; t.pop = pop; t.lat = lat;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          lat;
    int          p0;
    int          hi;
    int          early;

    //            wr  addr    data          strb  rxv rxd    txr resp         rdata         baud     ctrl  push pop lat
    tbl.push_back(v(0, 32'h08, 32'h0,        4'h0, 0, 8'h00, 1, RESP_OKAY,   32'h0000_01B2, 16'h01B2, 3'd0, 0, 0, 0));
    tbl.push_back(v(0, 32'h00, 32'h0,        4'h0, 0, 8'h00, 1, RESP_OKAY,   32'h0,         16'h01B2, 3'd0, 0, 0, 0));
    tbl.push_back(v(1, 32'h08, 32'h0000_ABCD, 4'h3, 0, 8'h00, 1, RESP_OKAY,  32'h0,         16'hABCD, 3'd0, 0, 0, 0));
    tbl.push_back(v(1, 32'h08, 32'h0000_01B2, 4'h3, 0, 8'h00, 1, RESP_OKAY,  32'h0,         16'h01B2, 3'd0, 0, 0, 0));
    tbl.push_back(v(0, 32'h08, 32'h0,        4'h0, 0, 8'h00, 1, RESP_OKAY,   32'h0000_01B2, 16'h01B2, 3'd0, 0, 0, 0));
    tbl.push_back(v(1, 32'h08, 32'h0000_FF77, 4'h1, 0, 8'h00, 1, RESP_OKAY,  32'h0,         16'h0177, 3'd0, 0, 0, 0));
    tbl.push_back(v(0, 32'h08, 32'h0,        4'h0, 0, 8'h00, 1, RESP_OKAY,   32'h0000_0177, 16'h0177, 3'd0, 0, 0, 0));
    tbl.push_back(v(1, 32'h00, 32'h0000_0017, 4'hF, 0, 8'h00, 1, RESP_OKAY,  32'h0,         16'h0177, 3'd7, 0, 0, 0));
    tbl.push_back(v(0, 32'h00, 32'h0,        4'h0, 0, 8'h00, 1, RESP_OKAY,   CTRL17_RB,     16'h0177, 3'd7, 0, 0, 0));
    tbl.push_back(v(1, 32'h00, 32'h0000_0005, 4'h0, 0, 8'h00, 1, RESP_OKAY,  32'h0,         16'h0177, 3'd7, 0, 0, 0));
    tbl.push_back(v(1, 32'h00, 32'h0000_0005, 4'h1, 0, 8'h00, 1, RESP_OKAY,  32'h0,         16'h0177, 3'd5, 0, 0, 0));
    tbl.push_back(v(0, 32'h00, 32'h0,        4'h0, 0, 8'h00, 1, RESP_OKAY,   32'h0000_0005, 16'h0177, 3'd5, 0, 0, 0));
    tbl.push_back(v(0, 32'h14, 32'h0,        4'h0, 0, 8'h00, 1, RESP_SLVERR, 32'h0,         16'h0177, 3'd5, 0, 0, 0));
    tbl.push_back(v(0, 32'h06, 32'h0,        4'h0, 0, 8'h00, 1, RESP_SLVERR, 32'h0,         16'h0177, 3'd5, 0, 0, 0));
    tbl.push_back(v(1, 32'h10, 32'h0000_00FF, 4'hF, 0, 8'h00, 1, RESP_SLVERR, 32'h0,        16'h0177, 3'd5, 0, 0, 0));
    tbl.push_back(v(0, 32'h0C, 32'h0,        4'h0, 0, 8'h00, 1, RESP_SLVERR, 32'h0,         16'h0177, 3'd5, 0, 0, 0));
    tbl.push_back(v(1, 32'h0A, 32'h0000_FFFF, 4'hF, 0, 8'h00, 1, RESP_SLVERR, 32'h0,        16'h0177, 3'd5, 0, 0, 0));
    tbl.push_back(v(0, 32'h1C, 32'h0,        4'h0, 0, 8'h00, 1, RESP_SLVERR, 32'h0,         16'h0177, 3'd5, 0, 0, 0));
    tbl.push_back(v(0, 32'h04, 32'h0,        4'h0, 0, 8'h00, 1, RESP_OKAY,   32'h0000_0001, 16'h0177, 3'd5, 0, 0, 0));
    tbl.push_back(v(1, 32'h0C, 32'h0000_0033, 4'h2, 0, 8'h00, 1, RESP_OKAY,  32'h0,         16'h0177, 3'd5, 0, 0, 0));
    tbl.push_back(v(1, 32'h0C, 32'h0000_005C, 4'h1, 0, 8'h00, 1, RESP_OKAY,  32'h0,         16'h0177, 3'd5, 1, 0, 1));
    tbl.push_back(v(0, 32'h10, 32'h0,        4'h0, 1, 8'h5A, 1, RESP_OKAY,   32'h0000_015A, 16'h0177, 3'd5, 0, 1, 0));
    tbl.push_back(v(0, 32'h10, 32'h0,        4'h0, 0, 8'hA5, 1, RESP_OKAY,   32'h0,         16'h0177, 3'd5, 0, 0, 0));
    tbl.push_back(v(0, 32'h04, 32'h0,        4'h0, 1, 8'h00, 0, RESP_OKAY,   STS_RXV,       16'h0177, 3'd5, 0, 0, 0));
    tbl.push_back(v(0, 32'h12, 32'h0,        4'h0, 1, 8'h77, 1, RESP_SLVERR, 32'h0,         16'h0177, 3'd5, 0, 0, 0));
    tbl.push_back(v(0, 32'h10, 32'h0,        4'h0, 1, 8'h00, 1, RESP_OKAY,   32'h0000_0100, 16'h0177, 3'd5, 0, 1, 0));

    req = '0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    rx_overrun = 1'b0;
    rst = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ar_ready", rsp.ar_ready, 0);
    check("rst_b_valid", rsp.b_valid, 0);
    check("rst_r_valid", rsp.r_valid, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_ctrl", {tx_en, rx_en, stop2}, 0);
    check("rst_baud", baud, 16'd434);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table
    for (int i = 0; i < tbl.size(); i++) begin
      tx_ready = tbl[i].txr;
      rx_valid = tbl[i].rxv;
      rx_data  = tbl[i].rxd;
      p0 = push_cnt;
      hi = pop_cnt;
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 1'b0, r, lat);
      end else begin
        do_read(tbl[i].addr, d, r, lat);
        check($sformatf("row%0d_rdata", i), d, tbl[i].rdata);
      end
      check($sformatf("row%0d_resp", i), r, tbl[i].resp);
      check($sformatf("row%0d_lat", i), lat, tbl[i].lat);
      check($sformatf("row%0d_baud", i), baud, tbl[i].baud);
      check($sformatf("row%0d_ctrl", i), {stop2, rx_en, tx_en}, tbl[i].ctrl);
      check($sformatf("row%0d_push", i), push_cnt - p0, tbl[i].push);
      check($sformatf("row%0d_pop", i), pop_cnt - hi, tbl[i].pop);
      rx_valid = 1'b0;
    end
    check("tx_data_last", tx_data, 8'h5C);

    // TX back-pressure: ready low for 5 cycles
    tx_ready = 1'b0;
    p0 = push_cnt;
    hi = 0;
    early = 0;
    req.aw.addr = 32'h0C;
    req.w.data  = 32'h41;
    req.w.strb  = 4'h1;
    req.aw_valid = 1'b1;
    req.w_valid  = 1'b1;
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (tx_valid && tx_data == 8'h41) hi++;
      if (rsp.b_valid) early++;
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    @(negedge clk);
    if (tx_valid && tx_data == 8'h41) hi++;
    if (rsp.b_valid) early++;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    check("tx_valid_cycles", hi, 6);
    check("tx_b_early", early, 0);
    check("tx_b_valid", rsp.b_valid, 1);
    check("tx_valid_drop", tx_valid, 0);
    check("tx_bresp", rsp.b.resp, RESP_OKAY);
    check("tx_push_once", push_cnt - p0, 1);
    req.b_ready = 1'b1;
    @(posedge clk); #1;
    req.b_ready = 1'b0;

    // Overrun sticky / W1C / set-wins
    pulse_overrun();
    do_read(32'h04, d, r, lat);
    check("ovr_set", d, STS_OVR);
    do_write(32'h04, 32'h4, 4'h0, 1'b0, r, lat);
    do_read(32'h04, d, r, lat);
    check("ovr_no_strb_keep", d, STS_OVR);
    do_write(32'h04, 32'h4, 4'h1, 1'b0, r, lat);
    check("ovr_w1c_resp", r, RESP_OKAY);
    do_read(32'h04, d, r, lat);
    check("ovr_cleared", d, 32'h0);
    do_write(32'h04, 32'h4, 4'h1, 1'b1, r, lat);
    do_read(32'h04, d, r, lat);
    check("ovr_set_wins", d, STS_OVR);
    do_write(32'h04, 32'h4, 4'h1, 1'b0, r, lat);
    do_read(32'h04, d, r, lat);
    check("ovr_cleared2", d, 32'h0);

`ifdef AXI_LITE_UART_IRQ_EN
    do_write(32'h00, 32'h10, 4'h1, 1'b0, r, lat);
    check("irq_idle", irq, 0);
    pulse_overrun();
    repeat (2) @(negedge clk);
    check("irq_on", irq, 1);
    do_write(32'h04, 32'h4, 4'h1, 1'b0, r, lat);
    repeat (2) @(negedge clk);
    check("irq_off", irq, 0);
`endif

    // Reset in the middle of W_TX
    do_write(32'h08, 32'h0000_1234, 4'h3, 1'b0, r, lat);
    do_write(32'h00, 32'h7, 4'h1, 1'b0, r, lat);
    p0 = push_cnt;
    tx_ready = 1'b0;
    req.aw.addr = 32'h0C;
    req.w.data  = 32'h99;
    req.w.strb  = 4'h1;
    req.aw_valid = 1'b1;
    req.w_valid  = 1'b1;
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_tx_valid", tx_valid, 1);
    check("pre_rst_baud", baud, 16'h1234);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_b_valid", rsp.b_valid, 0);
    check("mid_rst_ctrl", {tx_en, rx_en, stop2}, 0);
    check("mid_rst_baud", baud, 16'd434);
    check("mid_rst_tx_data", tx_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset in the middle of R_RESP
    req.ar.addr  = 32'h08;
    req.ar_valid = 1'b1;
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_r_valid", rsp.r_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_r_valid", rsp.r_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_read(32'h08, d, r, lat);
    check("post_rst_baud_rd", d, 32'h0000_01B2);
    check("post_rst_resp", r, RESP_OKAY);
    check("post_rst_no_push", push_cnt - p0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
